morse_rx_ctrl: RTL
==================

# morse_rx_ctrl

Receive-side controller for the Morse decoder. It takes a single push-button/switch key line from the board, times each press and each gap with a prescaled unit tick, and classifies presses as dot or dash. It accumulates up to four symbols per letter and, when the letter gap expires, presents the completed symbol code with a one-cycle valid strobe to the downstream letter-lookup and HEX display logic.

## Interface
Parameters:
- TICK_DIV, 25_000_000 — clock cycles per Morse time unit (0.5 s at 50 MHz). Must be ≥ 2.
- DASH_UNITS, 2 — a press lasting ≥ DASH_UNITS units is a dash; shorter is a dot.
- GAP_UNITS, 3 — a release lasting GAP_UNITS units ends the letter.

Ports:
- CLOCK_50  in  1  system clock. One clock domain only; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- key_in  in  1  raw key level, 1 = pressed; asynchronous to CLOCK_50.
- letter_valid  out  1  one-cycle strobe: letter_code, letter_len, and letter_err are newly updated.
- letter_code  out  4  symbols of the last letter, bit i = symbol i (0 = dot, 1 = dash), bit 0 = first symbol, unused bits 0.
- letter_len  out  3  symbol count of the last letter, 0–4.
- letter_err  out  1  last letter had more than 4 symbols.
- busy  out  1  letter in progress (state PRESS or GAP).

## Operation
- key_in passes through a 2-flop synchronizer to produce key_s. All timing refers to key_s.
- States:
  - IDLE: key_s=1 → PRESS.
  - PRESS: key_s=0 → GAP.
  - GAP: key_s=1 → PRESS; the low run reaching the gap threshold → EMIT.
  - EMIT: unconditional → IDLE.
- Press length L = consecutive cycles with key_s=1. Dash iff L ≥ DASH_UNITS*TICK_DIV, else dot. Any L ≥ 1 yields a symbol.
- The gap count G = consecutive key_s=0 cycles since the release. EMIT is entered after the cycle in which G reaches GAP_UNITS*TICK_DIV.
- The prescaler (0..TICK_DIV-1) and the unit counter restart on every key_s edge. The unit counter saturates at 7 and never wraps, so a key held indefinitely is a dash.
- On release, the classified symbol is written at index sym_cnt and sym_cnt increments.
  - If sym_cnt is already 4, the symbol is dropped and the internal overflow flag is set.
- EMIT (1 cycle):
  - letter_valid=1.
  - letter_code ← shift register, letter_len ← sym_cnt, letter_err ← overflow flag.
  - Shift register, sym_cnt, and overflow flag are cleared.
- Outputs letter_code, letter_len, and letter_err are registered and held until the next EMIT.
- reset, including mid-letter: state → IDLE; all counters, the shift register, the flags, and all outputs → 0. A partial letter is discarded with no strobe.

## Timing
- Reset values: letter_valid=0, letter_code=0, letter_len=0, letter_err=0, busy=0, synchronizer flops=0.
- key_in to key_s latency: 2 cycles.
- busy rises the cycle after key_s first goes high in IDLE. It falls the cycle after EMIT.
- letter_valid is high for exactly 1 cycle, one cycle after the G-th low cycle, with the data outputs updated in the same cycle.
- Simultaneous events:
  - A key press landing on the EMIT cycle is not lost. IDLE samples it the next cycle, and the press length is measured from that cycle (at most 1 cycle short).
  - A press starting on the same cycle the gap threshold would be reached continues the current letter, because the key_s=1 check takes priority in GAP.
- No backpressure: the consumer must accept letter_valid in the same cycle.

## Test plan
All scenarios use TICK_DIV=4, DASH_UNITS=2, GAP_UNITS=3, so dash ≥ 8 cycles and gap = 12 cycles.
- "A": press 4, release 4, press 8, release 20 → exactly one letter_valid, letter_code=4'b0010, letter_len=2, letter_err=0. Outputs hold afterwards.
- Dash threshold: single press of 7 cycles → code 0, len 1. Single press of 8 cycles → code 4'b0001, len 1.
- Gap threshold: dot, release 11 cycles, dot, release 12+ → one letter with len 2. Dot, release 12 → letter_valid with len 1.
- Overflow: five dots with 4-cycle gaps, then 12 low → len 4, code 0, err=1. The next letter "T" (one dash) → len 1, code 4'b0001, err=0.
- Reset mid-letter: two dashes, assert reset 1 cycle during the gap → no letter_valid, all outputs 0, busy 0. A following "E" (one dot) decodes normally.
- Saturation: hold the key for 100 cycles, then release 12 → len 1, code 4'b0001. busy stays high throughout the press.

Source files
------------

// File: rtl/morse_rx_ctrl.sv
// Morse key receiver: synchronizes the key line, times presses and gaps in unit
// ticks, builds up to four dot/dash symbols per letter and strobes out each letter.
module morse_rx_ctrl #(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned DASH_UNITS = 2,
  parameter int unsigned GAP_UNITS  = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_in,
  output logic       letter_valid,
  output logic [3:0] letter_code,
  output logic [2:0] letter_len,
  output logic       letter_err,
  output logic       busy
);

  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned UW      = 3;
  localparam int unsigned SW      = 3;
  localparam int unsigned CW      = 4;
  localparam int unsigned MAX_SYM = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_key_d;
  logic [PW-1:0]   r_presc;
  logic [UW-1:0]   r_units;
  logic [CW-1:0]   r_shreg;
  logic [SW-1:0]   r_sym_cnt;
  logic            r_ovf;

  logic            r_letter_valid;
  logic [CW-1:0]   r_letter_code;
  logic [SW-1:0]   r_letter_len;
  logic            r_letter_err;
  logic            r_busy;

  logic            w_key_s;
  logic            w_restart;
  logic [PW-1:0]   w_presc_nxt;
  logic [UW-1:0]   w_units_nxt;
  logic            w_gap_done;
  logic            w_release;
  logic            w_dash;
  logic            w_emit;
  logic            w_busy_nxt;
  logic            w_store;
  logic            w_drop;
  logic [CW-1:0]   w_shreg_set;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_key_d <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      r_key_d <= r_sync2;
    end
  end

  assign w_key_s = r_sync2;

  // A press seen first in IDLE (e.g. one that rose during EMIT) is timed from IDLE
  assign w_restart = (w_key_s ^ r_key_d) | ((r_state == S_IDLE) & w_key_s);

  // Counters hold run length so far: presc = len mod TICK_DIV, units = len / TICK_DIV (sat 7)
  always_comb begin
    w_presc_nxt = r_presc;
    w_units_nxt = r_units;
    if (w_restart) begin
      w_presc_nxt = PW'(1);
      w_units_nxt = '0;
    end else if (r_presc == PW'(TICK_DIV - 1)) begin
      w_presc_nxt = '0;
      if (r_units != UW'(7)) begin
        w_units_nxt = r_units + UW'(1);
      end
    end else begin
      w_presc_nxt = r_presc + PW'(1);
    end
  end

  assign w_gap_done = ~w_key_s & (w_units_nxt >= UW'(GAP_UNITS));
  assign w_release  = (r_state == S_PRESS) & ~w_key_s;
  assign w_dash     = (r_units >= UW'(DASH_UNITS));

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a new press in GAP wins over the gap timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_key_s) w_state_nxt = S_PRESS;
      S_PRESS: if (!w_key_s) w_state_nxt = S_GAP;
      S_GAP: begin
        if (w_key_s) begin
          w_state_nxt = S_PRESS;
        end else if (w_gap_done) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_emit      = 1'b0;
    w_busy_nxt  = 1'b0;
    w_store     = 1'b0;
    w_drop      = 1'b0;
    w_shreg_set = r_shreg | (CW'(w_dash) << r_sym_cnt[1:0]);
    if (w_state_nxt == S_EMIT) begin
      w_emit = 1'b1;
    end
    if ((w_state_nxt == S_PRESS) || (w_state_nxt == S_GAP)) begin
      w_busy_nxt = 1'b1;
    end
    if (w_release) begin
      if (r_sym_cnt < SW'(MAX_SYM)) begin
        w_store = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  // Timing counters, symbol accumulation and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_presc        <= '0;
      r_units        <= '0;
      r_shreg        <= '0;
      r_sym_cnt      <= '0;
      r_ovf          <= 1'b0;
      r_letter_valid <= 1'b0;
      r_letter_code  <= '0;
      r_letter_len   <= '0;
      r_letter_err   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_presc        <= w_presc_nxt;
      r_units        <= w_units_nxt;
      r_letter_valid <= w_emit;
      r_busy         <= w_busy_nxt;
      if (w_emit) begin
        r_letter_code <= r_shreg;
        r_letter_len  <= r_sym_cnt;
        r_letter_err  <= r_ovf;
        r_shreg       <= '0;
        r_sym_cnt     <= '0;
        r_ovf         <= 1'b0;
      end else begin
        if (w_store) begin
          r_shreg   <= w_shreg_set;
          r_sym_cnt <= r_sym_cnt + SW'(1);
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign letter_valid = r_letter_valid;
  assign letter_code  = r_letter_code;
  assign letter_len   = r_letter_len;
  assign letter_err   = r_letter_err;
  assign busy         = r_busy;

endmodule
